// File: rtl/vram_arbiter.sv
// Shares the character RAM between per-cell display fetch (slot at hc==HBP+8k-2, always wins) and terminal writes.
// Write grant is combinational, wr_ack follows one cycle later; next grant no sooner than 3 cycles; char outputs registered.
module vram_arbiter #(
   parameter int HBP    = 632,
   parameter int VBP    = 422,
   parameter int COLS   = 64,
   parameter int ROWS   = 16,
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              px_clk,
   input  logic              clr_n,
   input  logic [10:0]       hc,
   input  logic [10:0]       vc,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] char_code,
   output logic [3:0]        font_row,
   output logic              char_valid
);

   localparam logic [10:0]       SLOT_HC0 = 11'(HBP - 2);
   localparam logic [10:0]       CAP_HC0  = 11'(HBP - 1);
   localparam logic [10:0]       HC_LAST  = 11'(HBP + COLS * 8 - 1);
   localparam logic [10:0]       VC_FIRST = 11'(VBP);
   localparam logic [10:0]       VC_LAST  = 11'(VBP + ROWS * 16 - 1);
   localparam logic [7:0]        COLS_C   = 8'(COLS);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [ADDR_W:0]   CELLS    = (ADDR_W + 1)'(COLS * ROWS);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK} state_t;

   state_t            state_q, state_d;
   logic              wr_ack_q, wr_ack_d;
   logic [DATA_W-1:0] char_code_q, char_code_d;
   logic [3:0]        font_row_q, font_row_d;
   logic              char_valid_q, char_valid_d;

   logic [10:0]       vc_rel, hc_slot, hc_cap;
   logic              vc_vis, slot, capture, grant, in_range;
   logic [ADDR_W-1:0] disp_addr;

   // Offsets are only trusted after the >= guard, so wrapped small hc never aliases a slot.
   assign vc_rel    = vc - VC_FIRST;
   assign vc_vis    = (vc >= VC_FIRST) && (vc <= VC_LAST);
   assign hc_slot   = hc - SLOT_HC0;
   assign hc_cap    = hc - CAP_HC0;
   assign slot      = vc_vis && (hc >= SLOT_HC0) && (hc_slot[2:0] == 3'd0) && (hc_slot[10:3] < COLS_C);
   assign capture   = vc_vis && (hc >= CAP_HC0) && (hc_cap[2:0] == 3'd0) && (hc_cap[10:3] < COLS_C);
   assign disp_addr = ADDR_W'(vc_rel[10:4]) * COLS_A + ADDR_W'(hc_slot[10:3]);
   assign in_range  = {1'b0, wr_addr} < CELLS;

   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         S_IDLE: begin
            if (wr_req && !slot) begin
               grant   = 1'b1;
               state_d = S_WRITE;
            end
         end
         S_WRITE: state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      wr_ack_d = grant;
      if (slot) begin
         mem_addr = disp_addr;
      end else if (grant) begin
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
         mem_we    = in_range;
      end
   end

   // Capture lands one cycle after the slot read, so char_code spans exactly the 8 pixels of its cell.
   always_comb begin
      char_code_d  = char_code_q;
      font_row_d   = font_row_q;
      char_valid_d = char_valid_q;
      if (!vc_vis) begin
         char_valid_d = 1'b0;
      end else if (capture) begin
         char_code_d  = mem_rdata;
         font_row_d   = vc_rel[3:0];
         char_valid_d = 1'b1;
      end else if (hc == HC_LAST) begin
         char_valid_d = 1'b0;
      end
   end

   always_ff @(posedge px_clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q      <= S_IDLE;
         wr_ack_q     <= 1'b0;
         char_code_q  <= '0;
         font_row_q   <= '0;
         char_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ack_q     <= wr_ack_d;
         char_code_q  <= char_code_d;
         font_row_q   <= font_row_d;
         char_valid_q <= char_valid_d;
      end
   end

   assign wr_ack     = wr_ack_q;
   assign char_code  = char_code_q;
   assign font_row   = font_row_q;
   assign char_valid = char_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized sweep against a cycle-count based reference model.
module tb_vram_arbiter;
   localparam int HBP = 632, VBP = 422, COLS = 64, ROWS = 16;

   logic        px_clk = 1'b0, clr_n = 1'b1;
   logic [10:0] hc = '0, vc = '0, wr_addr = '0;
   logic        wr_req = 1'b0;
   logic [7:0]  wr_data = '0;
   logic        wr_ack, mem_we, char_valid;
   logic [10:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, char_code;
   logic [3:0]  font_row;
   logic [7:0]  ram [2048] = '{default: 8'h00};

   int total = 0, bad = 0;

   // reference model state: m_* = expected registered outputs now, n_* = after next edge
   int mram [2048];
   int cyc = 0, last_grant = -100, rd_prev = 0;
   int m_ack = 0, m_char = 0, m_frow = 0, m_valid = 0;
   int n_ack = 0, n_char = 0, n_frow = 0, n_valid = 0;
   int n_wr = 0, n_wa = 0, n_wd = 0;
   int e_addr = 0, e_we = 0, e_wdata = 0;

   always #5 px_clk = ~px_clk;

   vram_arbiter #(.HBP(HBP), .VBP(VBP), .COLS(COLS), .ROWS(ROWS), .ADDR_W(11), .DATA_W(8)) dut (
      .px_clk(px_clk), .clr_n(clr_n), .hc(hc), .vc(vc),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .char_code(char_code), .font_row(font_row), .char_valid(char_valid)
   );

   always @(posedge px_clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic model_reset();
      m_ack = 0; m_char = 0; m_frow = 0; m_valid = 0;
      n_ack = 0; n_char = 0; n_frow = 0; n_valid = 0; n_wr = 0;
      last_grant = -100;
      rd_prev = mram[0];
   endtask

   task automatic apply_reset();
      clr_n = 1'b0;
      #1;
   endtask

   task automatic release_reset();
      wr_req = 1'b0; hc = '0; vc = '0; wr_addr = '0; wr_data = '0;
      repeat (2) @(negedge px_clk);
      clr_n = 1'b1;
      model_reset();
   endtask

   // One pixel clock: drive inputs at negedge, then compute expectations from the display/write rules.
   task automatic drive(input int h, input int v, input bit req, input int a, input int d);
      bit vis, slot, cap, grant;
      int row, k;
      @(negedge px_clk);
      m_ack = n_ack; m_char = n_char; m_frow = n_frow; m_valid = n_valid;
      if (n_wr != 0) mram[n_wa] = n_wd;
      n_wr = 0;
      cyc++;
      hc = 11'(h); vc = 11'(v); wr_req = req; wr_addr = 11'(a); wr_data = 8'(d);
      #1;
      vis   = (v >= VBP) && (v <= VBP + ROWS * 16 - 1);
      row   = (v - VBP) / 16;
      k     = (h - HBP + 2) / 8;
      slot  = vis && (h >= HBP - 2) && ((h - HBP + 2) % 8 == 0) && (k < COLS);
      cap   = vis && (h >= HBP - 1) && ((h - HBP + 1) % 8 == 0) && ((h - HBP + 1) / 8 < COLS);
      grant = req && !slot && (cyc - last_grant >= 3);
      e_addr  = slot ? row * COLS + k : (grant ? a : 0);
      e_we    = (grant && a < COLS * ROWS) ? 1 : 0;
      e_wdata = grant ? d : 0;
      n_ack = grant ? 1 : 0;
      if (grant) last_grant = cyc;
      n_wr = e_we; n_wa = a; n_wd = d;
      n_char = m_char; n_frow = m_frow; n_valid = m_valid;
      if (!vis) n_valid = 0;
      else if (cap) begin n_char = rd_prev; n_frow = (v - VBP) % 16; n_valid = 1; end
      else if (h == HBP + COLS * 8 - 1) n_valid = 0;
      rd_prev = mram[e_addr];
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b want=0", wr_ack); end
      total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", char_valid); end
      total++; if (char_code !== 8'h00) begin bad++; $display("FAIL reset_code got=%0h want=0", char_code); end
      total++; if (font_row !== 4'h0) begin bad++; $display("FAIL reset_frow got=%0h want=0", font_row); end
      total++; if (mem_we !== 1'b0 || mem_addr !== 11'd0) begin bad++; $display("FAIL reset_bus got we=%0b addr=%0d want 0/0", mem_we, mem_addr); end
      release_reset();
   endtask

   task automatic test_write_free();
      drive(100, 10, 1, 5, 'h7A);
      total++; if (mem_we !== 1'b1 || mem_addr !== 11'd5 || mem_wdata !== 8'h7A) begin bad++; $display("FAIL free_grant got we=%0b addr=%0d data=%0h want 1/5/7a", mem_we, mem_addr, mem_wdata); end
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL free_ack_early got=%0b want=0", wr_ack); end
      drive(101, 10, 1, 5, 'h7A);
      total++; if (wr_ack !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL free_ack got ack=%0b we=%0b want 1/0", wr_ack, mem_we); end
      drive(102, 10, 0, 5, 'h7A);
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL free_ack_pulse got=%0b want=0", wr_ack); end
      total++; if (ram[5] !== 8'h7A) begin bad++; $display("FAIL free_ram got=%0h want=7a", ram[5]); end
   endtask

   task automatic test_display_fetch();
      int pa [3] = '{0, 1, 64};
      int pd [3] = '{'h41, 'h42, 'h55};
      for (int i = 0; i < 3; i++) begin
         drive(100, 10, 1, pa[i], pd[i]);
         drive(101, 10, 1, pa[i], pd[i]);
         drive(102, 10, 0, pa[i], pd[i]);
      end
      for (int h = 628; h <= 647; h++) begin
         drive(h, 422, 0, 0, 0);
         if (h == 630 || h == 638 || h == 646) begin
            total++; if (mem_addr !== 11'((h - 630) / 8) || mem_we !== 1'b0) begin bad++; $display("FAIL fetch_addr hc=%0d got addr=%0d we=%0b want %0d/0", h, mem_addr, mem_we, (h - 630) / 8); end
         end
         total++; if (char_valid !== (h >= 632)) begin bad++; $display("FAIL fetch_valid hc=%0d got=%0b", h, char_valid); end
         total++; if (char_code !== ((h < 632) ? 8'h00 : (h < 640) ? 8'h41 : 8'h42)) begin bad++; $display("FAIL fetch_code hc=%0d got=%0h", h, char_code); end
         if (h >= 632) begin
            total++; if (font_row !== 4'd0) begin bad++; $display("FAIL fetch_frow hc=%0d got=%0d want=0", h, font_row); end
         end
      end
   endtask

   task automatic test_row_font();
      drive(630, 439, 0, 0, 0);
      total++; if (mem_addr !== 11'd64 || mem_we !== 1'b0) begin bad++; $display("FAIL row_addr got addr=%0d we=%0b want 64/0", mem_addr, mem_we); end
      drive(631, 439, 0, 0, 0);
      drive(632, 439, 0, 0, 0);
      total++; if (font_row !== 4'd1 || char_valid !== 1'b1) begin bad++; $display("FAIL row_frow got frow=%0d valid=%0b want 1/1", font_row, char_valid); end
      total++; if (char_code !== 8'h55) begin bad++; $display("FAIL row_code got=%0h want=55", char_code); end
   endtask

   task automatic test_slot_collision();
      drive(629, 422, 0, 200, 'h33);
      drive(630, 422, 1, 200, 'h33);
      total++; if (mem_we !== 1'b0 || mem_addr !== 11'd0) begin bad++; $display("FAIL coll_slot got we=%0b addr=%0d want 0/0", mem_we, mem_addr); end
      drive(631, 422, 1, 200, 'h33);
      total++; if (mem_we !== 1'b1 || mem_addr !== 11'd200 || mem_wdata !== 8'h33) begin bad++; $display("FAIL coll_grant got we=%0b addr=%0d data=%0h want 1/200/33", mem_we, mem_addr, mem_wdata); end
      drive(632, 422, 1, 200, 'h33);
      total++; if (wr_ack !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL coll_ack got ack=%0b we=%0b want 1/0", wr_ack, mem_we); end
      total++; if (char_code !== 8'h41) begin bad++; $display("FAIL coll_code got=%0h want=41", char_code); end
      drive(633, 422, 0, 200, 'h33);
      total++; if (wr_ack !== 1'b0 || ram[200] !== 8'h33) begin bad++; $display("FAIL coll_done got ack=%0b ram=%0h want 0/33", wr_ack, ram[200]); end
   endtask

   task automatic test_out_of_range();
      drive(200, 10, 1, 1024, 'h99);
      total++; if (mem_we !== 1'b0 || mem_addr !== 11'd1024) begin bad++; $display("FAIL oor_drop got we=%0b addr=%0d want 0/1024", mem_we, mem_addr); end
      drive(201, 10, 1, 1024, 'h99);
      total++; if (wr_ack !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL oor_ack got ack=%0b we=%0b want 1/0", wr_ack, mem_we); end
      drive(202, 10, 0, 1024, 'h99);
      total++; if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL oor_end got ack=%0b we=%0b want 0/0", wr_ack, mem_we); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         drive(300 + i, 10, 1, 10 + (i + 1) / 3, 'h10 + (i + 1) / 3);
         total++; if (mem_we !== (i % 3 == 0)) begin bad++; $display("FAIL b2b_we i=%0d got=%0b", i, mem_we); end
         total++; if (mem_wdata !== ((i % 3 == 0) ? 8'('h10 + i / 3) : 8'h00)) begin bad++; $display("FAIL b2b_data i=%0d got=%0h", i, mem_wdata); end
         total++; if (wr_ack !== (i % 3 == 1)) begin bad++; $display("FAIL b2b_ack i=%0d got=%0b", i, wr_ack); end
      end
      total++; if (ram[13] !== 8'h13) begin bad++; $display("FAIL b2b_ram got=%0h want=13", ram[13]); end
   endtask

   task automatic test_reset_mid();
      for (int h = 628; h <= 632; h++) drive(h, 422, 0, 0, 0);
      drive(633, 422, 1, 300, 'h66);
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%0b want=1", mem_we); end
      drive(634, 422, 1, 300, 'h66);
      total++; if (wr_ack !== 1'b1 || char_valid !== 1'b1 || char_code !== 8'h41) begin bad++; $display("FAIL rmid_pre got ack=%0b valid=%0b code=%0h want 1/1/41", wr_ack, char_valid, char_code); end
      apply_reset();
      total++; if (wr_ack !== 1'b0 || char_valid !== 1'b0 || char_code !== 8'h00 || font_row !== 4'h0) begin bad++; $display("FAIL rmid_async got ack=%0b valid=%0b code=%0h frow=%0h want all 0", wr_ack, char_valid, char_code, font_row); end
      release_reset();
      drive(100, 10, 1, 301, 'h67);
      total++; if (mem_we !== 1'b1 || mem_addr !== 11'd301) begin bad++; $display("FAIL rmid_idle got we=%0b addr=%0d want 1/301", mem_we, mem_addr); end
      drive(101, 10, 1, 301, 'h67);
      total++; if (wr_ack !== 1'b1 || ram[300] !== 8'h66 || ram[301] !== 8'h67) begin bad++; $display("FAIL rmid_after got ack=%0b ram300=%0h ram301=%0h want 1/66/67", wr_ack, ram[300], ram[301]); end
      drive(102, 10, 0, 301, 'h67);
   endtask

   task automatic test_random();
      bit pend = 0, saw_ack = 0;
      int pa = 0, pd = 0, v;
      for (int line = 0; line < 6; line++) begin
         v = (line == 0) ? 422 : (line == 5) ? 677 : $urandom_range(682, 416);
         for (int h = 620; h < 1150; h++) begin
            if (saw_ack) pend = 0;
            if (!pend && $urandom_range(3) == 0) begin
               pend = 1;
               pa = $urandom_range(1099, 0);
               pd = $urandom_range(255, 0);
            end
            drive(h, v, pend, pa, pd);
            total++; if (mem_addr !== 11'(e_addr) || mem_we !== e_we[0] || mem_wdata !== 8'(e_wdata)) begin bad++; $display("FAIL rnd_bus hc=%0d vc=%0d got %0d/%0b/%0h want %0d/%0d/%0h", h, v, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wdata); end
            total++; if (wr_ack !== m_ack[0]) begin bad++; $display("FAIL rnd_ack hc=%0d got=%0b want=%0d", h, wr_ack, m_ack); end
            total++; if (char_valid !== m_valid[0] || char_code !== 8'(m_char) || font_row !== 4'(m_frow)) begin bad++; $display("FAIL rnd_char hc=%0d vc=%0d got %0b/%0h/%0d want %0d/%0h/%0d", h, v, char_valid, char_code, font_row, m_valid, m_char, m_frow); end
            saw_ack = (m_ack == 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_free();
      test_display_fetch();
      test_row_font();
      test_slot_collision();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
